// File: rtl/ahb_flash_reader_qspi_pkg.sv
// Shared types and constants for the AHB QSPI flash reader: sequencer states,
// phase lengths, the default read opcode and the hit-buffer entry.
package ahb_flash_reader_qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } seq_state_e;

  // Phase lengths in SCK cycles
  localparam int CMD_LEN  = 8;
  localparam int ADDR_LEN = 6;
  localparam int MODE_LEN = 2;
  localparam int DATA_LEN = 8;
  localparam int CNT_W    = 5;

  localparam logic [7:0] DEF_OPCODE = 8'hEB;
  // IO3/IO2 = HOLD#/WP# held high while the flash is in single-bit mode
  localparam logic [3:0] IO_IDLE    = 4'b1100;

  typedef struct packed {
    logic        vld;
    logic [21:0] tag;
    logic [31:0] data;
  } hit_buf_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ahb_flash_reader_qspi_qspi_rd_seq.sv
// Quad I/O Fast Read sequencer: sends opcode, address, mode and dummy cycles,
// then collects one 32-bit word. SCK runs at HCLK/2, low phase first.
module qspi_rd_seq
  import ahb_flash_reader_qspi_pkg::*;
#(
  parameter logic [7:0] CMD_OPCODE   = DEF_OPCODE,
  parameter logic [7:0] MODE_BITS    = 8'hFF,
  parameter int         DUMMY_CYCLES = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic [21:0] waddr,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fr_sck,
  output logic        fr_ce_n,
  output logic [3:0]  fr_dout,
  output logic        fr_douten,
  input  logic [3:0]  fr_din
);

  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_LEN - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_LEN - 1);
  localparam logic [CNT_W-1:0] MODE_LAST  = CNT_W'(MODE_LEN - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ph_q, ph_d;
  logic [21:0]      addr_q, addr_d;
  logic [31:0]      sr_q, sr_d;
  logic [3:0]       addr_nib;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      addr_q  <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      addr_q  <= addr_d;
      sr_q    <= sr_d;
    end
  end

  // cnt_q holds SCK cycles left in the current phase; everything advances
  // on the HCLK edge that closes a high phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    addr_d  = addr_q;
    sr_d    = sr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        ph_d    = 1'b0;
        if (start) begin
          state_d = ST_CMD;
          cnt_d   = CMD_LAST;
          addr_d  = waddr;
        end
      end
      default: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (state_q == ST_DATA) sr_d = {sr_q[27:0], fr_din};
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            case (state_q)
              ST_CMD:  begin state_d = ST_ADDR; cnt_d = ADDR_LAST; end
              ST_ADDR: begin state_d = ST_MODE; cnt_d = MODE_LAST; end
              ST_MODE: begin
                if (DUMMY_CYCLES == 0) begin
                  state_d = ST_DATA;
                  cnt_d   = DATA_LAST;
                end else begin
                  state_d = ST_DUMMY;
                  cnt_d   = DUMMY_LAST;
                end
              end
              ST_DUMMY: begin state_d = ST_DATA; cnt_d = DATA_LAST; end
              default:  state_d = ST_DONE;
            endcase
          end
        end
      end
    endcase
  end

  // Outputs decode straight from state/counter, so they only move when the
  // counter does, i.e. at the start of a low phase.
  assign addr_nib = 4'({addr_q, 2'b00} >> {cnt_q[2:0], 2'b00});

  always_comb begin
    fr_douten = 1'b0;
    fr_dout   = IO_IDLE;
    case (state_q)
      ST_CMD: begin
        fr_douten = 1'b1;
        fr_dout   = {IO_IDLE[3:1], CMD_OPCODE[cnt_q[2:0]]};
      end
      ST_ADDR: begin
        fr_douten = 1'b1;
        fr_dout   = addr_nib;
      end
      ST_MODE: begin
        fr_douten = 1'b1;
        fr_dout   = cnt_q[0] ? MODE_BITS[7:4] : MODE_BITS[3:0];
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign ready   = ~busy;
  assign done    = (state_q == ST_DONE);
  assign fr_ce_n = ~busy;
  assign fr_sck  = ph_q & busy;
  // Bytes arrive in flash order, first byte ends up in the top of sr_q
  assign rdata   = bswap32(sr_q);

endmodule

// File: rtl/ahb_flash_reader_qspi.sv
// AHB-Lite read-only slave in front of a QSPI NOR flash, with a single-word
// hit buffer so repeated reads of one word need no flash access.
module ahb_flash_reader_qspi
  import ahb_flash_reader_qspi_pkg::*;
#(
  parameter logic [7:0] CMD_OPCODE   = DEF_OPCODE,
  parameter logic [7:0] MODE_BITS    = 8'hFF,
  parameter int         DUMMY_CYCLES = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        wr_lock,
  output logic        fr_sck,
  output logic        fr_ce_n,
  output logic [3:0]  fr_dout,
  output logic        fr_douten,
  input  logic [3:0]  fr_din
);

  logic        accept, rd, hit, start;
  logic [21:0] waddr;
  logic [31:0] hit_data;
  logic        seq_ready, seq_busy, seq_done;
  logic [31:0] seq_data;
  hit_buf_t    buf_q;
  logic [21:0] miss_tag_q;
  logic        dp_hit_q;
  logic [31:0] dp_data_q;
  logic        unused_ok;

  assign unused_ok = ^{HWDATA, HSIZE, HADDR[31:24], HADDR[1:0], HTRANS[0]};

  assign waddr  = HADDR[23:2];
  assign accept = HSEL & HREADY & HTRANS[1];
  assign rd     = accept & ~HWRITE;

  // While a fetch sits in DONE the buffer is being overwritten on this very
  // edge, so the incoming word replaces the stored one for hit detection.
  always_comb begin
    if (seq_done) begin
      hit      = (miss_tag_q == waddr);
      hit_data = seq_data;
    end else begin
      hit      = buf_q.vld && (buf_q.tag == waddr);
      hit_data = buf_q.data;
    end
  end

  assign start = rd & ~wr_lock & ~hit & seq_ready;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      buf_q      <= '0;
      miss_tag_q <= '0;
      dp_hit_q   <= 1'b0;
      dp_data_q  <= '0;
    end else begin
      if (wr_lock) begin
        buf_q.vld <= 1'b0;
      end else if (seq_done) begin
        buf_q.vld  <= 1'b1;
        buf_q.tag  <= miss_tag_q;
        buf_q.data <= seq_data;
      end
      if (start) miss_tag_q <= waddr;
      if (HREADY) begin
        dp_hit_q  <= rd & ~wr_lock & hit;
        dp_data_q <= hit_data;
      end
    end
  end

  assign HREADYOUT = ~seq_busy;
  assign HRDATA    = seq_done ? seq_data : (dp_hit_q ? dp_data_q : 32'h0);

  qspi_rd_seq #(
    .CMD_OPCODE  (CMD_OPCODE),
    .MODE_BITS   (MODE_BITS),
    .DUMMY_CYCLES(DUMMY_CYCLES)
  ) u_seq (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .start    (start),
    .waddr    (waddr),
    .ready    (seq_ready),
    .busy     (seq_busy),
    .done     (seq_done),
    .rdata    (seq_data),
    .fr_sck   (fr_sck),
    .fr_ce_n  (fr_ce_n),
    .fr_dout  (fr_dout),
    .fr_douten(fr_douten),
    .fr_din   (fr_din)
  );

endmodule

// File: tb/tb_ahb_flash_reader_qspi.sv
// Bench for ahb_flash_reader_qspi: behavioural QSPI flash + pin monitor, an
// AHB master, and a one-entry buffer model predicting hit/miss and data.
module tb_ahb_flash_reader_qspi;

  localparam int MISS_WAITS = 2 * (24 + 4);

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        wr_lock;
  logic        fr_sck, fr_ce_n, fr_douten;
  logic [3:0]  fr_dout, fr_din;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_flash_reader_qspi dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HSIZE(HSIZE), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .wr_lock(wr_lock), .fr_sck(fr_sck), .fr_ce_n(fr_ce_n),
    .fr_dout(fr_dout), .fr_douten(fr_douten), .fr_din(fr_din)
  );

  // Flash model: 1 KiB array, counts SCK rising edges per chip-select window
  logic [7:0]  mem [0:1023];
  int          n_edge = 0;
  int          n_access = 0;
  int          mon_err = 0;
  logic [7:0]  mon_cmd = 8'h0;
  logic [23:0] mon_addr = 24'h0;
  logic [7:0]  mon_mode = 8'h0;
  logic [3:0]  din_r = 4'h0;
  int          fk, fb;
  logic [7:0]  fbyte;

  assign fr_din = din_r;

  always @(negedge fr_ce_n) begin
    n_edge = 0;
    mon_err = 0;
    n_access++;
  end

  always @(posedge fr_sck) begin
    if (!fr_ce_n) begin
      if (n_edge < 16 && fr_douten !== 1'b1) mon_err++;
      if (n_edge >= 16 && fr_douten !== 1'b0) mon_err++;
      if (n_edge < 8) begin
        if (fr_dout[3:1] !== 3'b110) mon_err++;
        mon_cmd = {mon_cmd[6:0], fr_dout[0]};
      end else if (n_edge < 14) begin
        mon_addr = {mon_addr[19:0], fr_dout};
      end else if (n_edge < 16) begin
        mon_mode = {mon_mode[3:0], fr_dout};
      end else if (n_edge >= 20 && n_edge < 28) begin
        fk = n_edge - 20;
        fb = (int'(mon_addr[9:0]) + fk / 2) % 1024;
        fbyte = mem[fb];
        din_r <= (fk % 2 == 0) ? fbyte[7:4] : fbyte[3:0];
      end
      n_edge++;
    end
  end

  int          total = 0;
  int          bad = 0;
  logic        mvalid;
  logic [21:0] mtag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flash_word(input logic [31:0] a);
    int b;
    b = int'(a[9:2]) * 4;
    return {mem[b + 3], mem[b + 2], mem[b + 1], mem[b]};
  endfunction

  // Called at #1 after a posedge with HREADYOUT high
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int waits);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    waits = 0;
    while (HREADYOUT !== 1'b1 && waits < 200) begin
      waits++;
      @(posedge HCLK); #1;
    end
    d = HRDATA;
  endtask

  task automatic check_read(input string tag, input logic [31:0] a, output logic [31:0] d);
    int          acc0, w, exp_w, exp_acc;
    logic [31:0] exp_d;
    logic        miss;
    acc0 = n_access;
    miss = 1'b0;
    if (wr_lock) begin
      exp_d = 32'h0; exp_w = 0; exp_acc = acc0; mvalid = 1'b0;
    end else if (mvalid && mtag == a[23:2]) begin
      exp_d = flash_word(a); exp_w = 0; exp_acc = acc0;
    end else begin
      exp_d = flash_word(a); exp_w = MISS_WAITS; exp_acc = acc0 + 1;
      mvalid = 1'b1; mtag = a[23:2]; miss = 1'b1;
    end
    do_read(a, d, w);
    chk({tag, "/data"}, d, exp_d);
    chk({tag, "/waits"}, 32'(w), 32'(exp_w));
    chk({tag, "/accesses"}, 32'(n_access), 32'(exp_acc));
    if (miss) begin
      chk({tag, "/cmd"}, {24'h0, mon_cmd}, 32'hEB);
      chk({tag, "/addr"}, {8'h0, mon_addr}, {8'h0, a[23:2], 2'b00});
      chk({tag, "/mode"}, {24'h0, mon_mode}, 32'hFF);
      chk({tag, "/pinerr"}, 32'(mon_err), 32'h0);
    end else begin
      chk({tag, "/ce_n"}, {31'h0, fr_ce_n}, 32'h1);
    end
  endtask

  task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] wd);
    int acc0, w;
    acc0 = n_access;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wd;
    w = 0;
    while (HREADYOUT !== 1'b1 && w < 200) begin
      w++;
      @(posedge HCLK); #1;
    end
    chk({tag, "/waits"}, 32'(w), 32'h0);
    chk({tag, "/hrdata"}, HRDATA, 32'h0);
    chk({tag, "/accesses"}, 32'(n_access), 32'(acc0));
  endtask

  logic [9:0]  pool [5];
  logic [31:0] d, a;
  int          r;

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = 32'h0; HWDATA = 32'h0; HSIZE = 3'b010; wr_lock = 1'b0;
    mvalid = 1'b0; mtag = '0;
    pool = '{10'h100, 10'h104, 10'h108, 10'h2F0, 10'h3FC};
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;

    #12;
    chk("rst/ce_n", {31'h0, fr_ce_n}, 32'h1);
    chk("rst/sck", {31'h0, fr_sck}, 32'h0);
    chk("rst/dout", {28'h0, fr_dout}, 32'hC);
    chk("rst/douten", {31'h0, fr_douten}, 32'h0);
    chk("rst/hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("rst/hrdata", HRDATA, 32'h0);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Cold miss, then immediate re-read hits in the buffer
    check_read("t1", 32'h0000_0100, d);
    chk("t1/known", d, 32'h4433_2211);
    check_read("t2", 32'h0000_0100, d);
    chk("t2/known", d, 32'h4433_2211);

    // Single entry: a different word evicts 0x100
    check_read("t3a", 32'h0000_0104, d);
    check_read("t3b", 32'h0000_0100, d);

    // wr_lock pulse invalidates; locked read returns 0 without flash access
    wr_lock = 1'b1; @(posedge HCLK); #1; wr_lock = 1'b0; mvalid = 1'b0;
    check_read("t4a", 32'h0000_0100, d);
    wr_lock = 1'b1;
    check_read("t4b", 32'h0000_0100, d);
    wr_lock = 1'b0;
    @(posedge HCLK); #1;

    // Reset in the middle of a miss
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_0108;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (19) @(posedge HCLK);
    #1;
    chk("t5/mid_ce_n", {31'h0, fr_ce_n}, 32'h0);
    chk("t5/mid_sck", {31'h0, fr_sck}, 32'h1);
    chk("t5/mid_hreadyout", {31'h0, HREADYOUT}, 32'h0);
    HRESETn = 1'b0; #1;
    chk("t5/ce_n", {31'h0, fr_ce_n}, 32'h1);
    chk("t5/sck", {31'h0, fr_sck}, 32'h0);
    chk("t5/hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("t5/hrdata", HRDATA, 32'h0);
    chk("t5/douten", {31'h0, fr_douten}, 32'h0);
    mvalid = 1'b0;
    @(posedge HCLK); #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    check_read("t5", 32'h0000_0108, d);

    // Writes are ignored
    check_read("t6a", 32'h0000_0100, d);
    check_write("t6w", 32'h0000_0100, 32'hDEAD_BEEF);
    check_read("t6b", 32'h0000_0100, d);

    // Random mix over a small address pool; upper and byte-lane bits are noise
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      a = {8'($urandom), 14'h0, pool[$urandom_range(0, 4)][9:2], 2'($urandom)};
      if (r == 0) begin
        wr_lock = 1'b1; @(posedge HCLK); #1; wr_lock = 1'b0; mvalid = 1'b0;
      end else if (r == 1) begin
        check_write("rnd_w", a, $urandom);
      end else if (r == 2) begin
        wr_lock = 1'b1;
        check_read("rnd_lock", a, d);
        wr_lock = 1'b0;
      end else begin
        check_read("rnd_r", a, d);
      end
    end

    @(posedge HCLK); #1;
    chk("idle/hrdata", HRDATA, 32'h0);
    chk("idle/ce_n", {31'h0, fr_ce_n}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
